zxuno_regport_master: RTL and testbench



---
 rtl/zxuno_regbus_pkg.sv | 17 +
 rtl/zxuno_sync2.sv | 25 ++
 rtl/zxuno_regport_master.sv | 107 ++++++++++
 tb/tb_zxuno_regport_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/zxuno_regbus_pkg.sv
// Shared definitions for the ZX-Uno internal register bus: port addresses,
// initiator state encoding and well-known register numbers.
package zxuno_regbus_pkg;

  localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

  localparam logic [7:0] ZXUNO_REG_SCRATCH = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } st_e;

endpackage

// File: rtl/zxuno_sync2.sv
// Two-flop synchroniser for an active-low Z80 strobe; both stages preset to
// the inactive level so a reset never looks like an access.
module zxuno_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/zxuno_regport_master.sv
// Register-bus initiator: decodes Z80 I/O to the address/data ports, holds the
// register number and issues one read or write strobe per CPU access.
module zxuno_regport_master
  import zxuno_regbus_pkg::*;
#(
  parameter logic [15:0] ADDR_PORT  = ZXUNO_ADDR_PORT,
  parameter logic [15:0] DATA_PORT  = ZXUNO_DATA_PORT,
  parameter logic [7:0]  ADDR_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_wdata,
  input  logic [7:0]  reg_rdata
);

  logic iorqSync_n, rdSync_n, wrSync_n, m1Sync_n;

  zxuno_sync2 u_syncIorq (.clk_i(clk), .rst_ni(rst_n), .d_i(iorq_n), .q_o(iorqSync_n));
  zxuno_sync2 u_syncRd   (.clk_i(clk), .rst_ni(rst_n), .d_i(rd_n),   .q_o(rdSync_n));
  zxuno_sync2 u_syncWr   (.clk_i(clk), .rst_ni(rst_n), .d_i(wr_n),   .q_o(wrSync_n));
  zxuno_sync2 u_syncM1   (.clk_i(clk), .rst_ni(rst_n), .d_i(m1_n),   .q_o(m1Sync_n));

  logic addrHit, dataHit, rawSel, syncAccess;

  assign addrHit    = (a == ADDR_PORT);
  assign dataHit    = (a == DATA_PORT);
  assign rawSel     = ~iorq_n & m1_n & (addrHit | dataHit);
  assign syncAccess = ~iorqSync_n & m1Sync_n & (~rdSync_n | ~wrSync_n) & (addrHit | dataHit);

  st_e        st_q;
  logic [7:0] addr_q, wdata_q, rdLatch_q, pending_q;
  logic       regrd_q, regwr_q, isData_q, isWrite_q;
  logic [1:0] settle_q;

  // settle_q masks the preset value still sitting in the synchronisers after
  // reset, so an access in flight at reset release cannot leave HOLD early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_HOLD;
      addr_q    <= ADDR_RESET;
      wdata_q   <= 8'h00;
      rdLatch_q <= 8'hFF;
      pending_q <= 8'h00;
      regrd_q   <= 1'b0;
      regwr_q   <= 1'b0;
      isData_q  <= 1'b0;
      isWrite_q <= 1'b0;
      settle_q  <= 2'b00;
    end else begin
      settle_q <= {settle_q[0], 1'b1};
      regrd_q  <= 1'b0;
      regwr_q  <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (syncAccess) begin
            st_q      <= ST_ISSUE;
            isData_q  <= dataHit;
            isWrite_q <= ~wrSync_n;
            pending_q <= cpu_din;
            regwr_q   <= dataHit & ~wrSync_n;
            regrd_q   <= dataHit & wrSync_n;
            if (dataHit & ~wrSync_n) begin
              wdata_q <= cpu_din;
            end
          end
        end
        ST_ISSUE: begin
          if (isWrite_q & ~isData_q) begin
            addr_q <= pending_q;
          end
          st_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (isData_q & ~isWrite_q) begin
            rdLatch_q <= reg_rdata;
          end
          st_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (settle_q[1] & iorqSync_n) begin
            st_q <= ST_IDLE;
          end
        end
        default: st_q <= ST_HOLD;
      endcase
    end
  end

  assign cpu_oe_n    = ~(rawSel & ~rd_n);
  assign cpu_dout    = addrHit ? addr_q : rdLatch_q;
  assign zxuno_addr  = addr_q;
  assign zxuno_regrd = regrd_q;
  assign zxuno_regwr = regwr_q;
  assign zxuno_wdata = wdata_q;

endmodule

// File: tb/tb_zxuno_regport_master.sv
// Self-checking bench: directed port accesses followed by random back-to-back
// accesses, compared against a register-file model of the bus.
module tb_zxuno_regport_master;

  localparam logic [15:0] ADDR_PORT  = 16'hFC3B;
  localparam logic [15:0] DATA_PORT  = 16'hFD3B;
  localparam logic [15:0] OTHER_PORT = 16'h003B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        m1_n = 1'b1;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_oe_n;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;
  logic [7:0]  zxuno_wdata;
  logic [7:0]  reg_rdata;

  int checks = 0;
  int failures = 0;
  int regwrCount = 0;
  int regrdCount = 0;
  int bothCount = 0;
  logic [7:0] lastWdata = 8'h00;

  logic [7:0] respMem [256];
  bit         respWritten [256];
  logic [7:0] modelMem [256];
  logic [7:0] modelAddr = 8'h00;
  int         modelStrobes = 0;

  int         wrMark;
  bit         seen;

  always #5 clk = ~clk;

  zxuno_regport_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .m1_n       (m1_n),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_oe_n   (cpu_oe_n),
    .zxuno_addr (zxuno_addr),
    .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr),
    .zxuno_wdata(zxuno_wdata),
    .reg_rdata  (reg_rdata)
  );

  function automatic logic [7:0] initVal(input logic [7:0] r);
    return r ^ 8'h3C;
  endfunction

  // Responder bank: registers writes on the strobe edge, read data muxed by address.
  assign reg_rdata = respWritten[zxuno_addr] ? respMem[zxuno_addr] : initVal(zxuno_addr);

  always @(posedge clk) begin
    if (zxuno_regwr) begin
      respMem[zxuno_addr]     <= zxuno_wdata;
      respWritten[zxuno_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (zxuno_regwr) begin
      regwrCount = regwrCount + 1;
      lastWdata  = zxuno_wdata;
    end
    if (zxuno_regrd) regrdCount = regrdCount + 1;
    if (zxuno_regwr && zxuno_regrd) bothCount = bothCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete Z80 I/O cycle; waits stretches it like Z80 wait states.
  task automatic applyStimulus(input logic [15:0] addr, input bit isWrite, input logic [7:0] din,
                               input bit m1Low, input int waits, input string tag);
    int wrBefore, rdBefore;
    bit valid, isAddr, isData;
    logic [7:0] expDout;
    @(negedge clk);
    #2;
    wrBefore = regwrCount;
    rdBefore = regrdCount;
    isAddr   = (addr == ADDR_PORT);
    isData   = (addr == DATA_PORT);
    valid    = !m1Low && (isAddr || isData);
    expDout  = isAddr ? modelAddr : modelMem[modelAddr];
    a        = addr;
    cpu_din  = din;
    m1_n     = !m1Low;
    iorq_n   = 1'b0;
    if (isWrite) wr_n = 1'b0;
    else         rd_n = 1'b0;
    repeat (6 + waits) @(negedge clk);
    #1;
    checkOutput($sformatf("%s oe_n", tag), 32'(cpu_oe_n), 32'((valid && !isWrite) ? 1'b0 : 1'b1));
    if (valid && !isWrite) checkOutput($sformatf("%s dout", tag), 32'(cpu_dout), 32'(expDout));
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
    if (valid && isWrite) begin
      if (isAddr) modelAddr = din;
      else        modelMem[modelAddr] = din;
    end
    if (valid && isData) modelStrobes = modelStrobes + 1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput($sformatf("%s regwr count", tag), 32'(regwrCount - wrBefore), 32'(valid && isData && isWrite));
    checkOutput($sformatf("%s regrd count", tag), 32'(regrdCount - rdBefore), 32'(valid && isData && !isWrite));
    if (valid && isData && isWrite) checkOutput($sformatf("%s wdata", tag), 32'(lastWdata), 32'(din));
    checkOutput($sformatf("%s reg number", tag), 32'(zxuno_addr), 32'(modelAddr));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 256; i++) modelMem[i] = initVal(8'(i));

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset regrd", 32'(zxuno_regrd), 32'(1'b0));
    checkOutput("reset regwr", 32'(zxuno_regwr), 32'(1'b0));
    checkOutput("reset wdata", 32'(zxuno_wdata), 32'(8'h00));
    checkOutput("reset reg number", 32'(zxuno_addr), 32'(8'h00));
    checkOutput("reset rd latch", 32'(cpu_dout), 32'(8'hFF));
    checkOutput("reset oe_n", 32'(cpu_oe_n), 32'(1'b1));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus(ADDR_PORT, 1'b1, 8'hFE, 1'b0, 0, "wrAddr");
    applyStimulus(ADDR_PORT, 1'b0, 8'h00, 1'b0, 0, "rdAddr");
    applyStimulus(DATA_PORT, 1'b1, 8'h5A, 1'b0, 3, "wrDataWait");
    applyStimulus(DATA_PORT, 1'b0, 8'h00, 1'b0, 0, "rdData");
    applyStimulus(DATA_PORT, 1'b0, 8'h00, 1'b1, 0, "intAck");
    applyStimulus(OTHER_PORT, 1'b0, 8'h00, 1'b0, 0, "otherRd");
    applyStimulus(OTHER_PORT, 1'b1, 8'h77, 1'b0, 0, "otherWr");

    // Reset asserted and released while a data-port write is still active.
    @(negedge clk);
    #2;
    wrMark  = regwrCount;
    a       = DATA_PORT;
    cpu_din = 8'h33;
    iorq_n  = 1'b0;
    wr_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelAddr = 8'h00;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("midReset regwr count", 32'(regwrCount - wrMark), 32'(0));
    checkOutput("midReset reg number", 32'(zxuno_addr), 32'(8'h00));
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(DATA_PORT, 1'b1, 8'hC3, 1'b0, 0, "postReset");

    // Reset landing on a live strobe must clear it without waiting for a clock.
    applyStimulus(ADDR_PORT, 1'b1, 8'h05, 1'b0, 0, "preDrop");
    @(negedge clk);
    #2;
    a       = DATA_PORT;
    cpu_din = 8'h99;
    iorq_n  = 1'b0;
    wr_n    = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (zxuno_regwr) seen = 1'b1;
    end
    checkOutput("drop strobe seen", 32'(seen), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    checkOutput("drop async regwr", 32'(zxuno_regwr), 32'(1'b0));
    checkOutput("drop reg number", 32'(zxuno_addr), 32'(8'h00));
    modelAddr = 8'h00;
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 100; n++) begin
      logic [15:0] rAddr;
      bit          rWrite, rM1;
      logic [7:0]  rDin;
      int          sel;
      sel    = int'($urandom_range(0, 9));
      rAddr  = (sel < 4) ? ADDR_PORT : ((sel < 9) ? DATA_PORT : OTHER_PORT);
      rWrite = 1'($urandom_range(0, 1));
      rM1    = ($urandom_range(0, 7) == 0);
      rDin   = (rAddr == ADDR_PORT) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      if (rAddr == ADDR_PORT && $urandom_range(0, 4) == 0) rDin = 8'hFE;
      applyStimulus(rAddr, rWrite, rDin, rM1, int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    checkOutput("total strobes", 32'(regwrCount + regrdCount), 32'(modelStrobes));
    checkOutput("simultaneous strobes", 32'(bothCount), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
